// File: rtl/par_mem_pkg.sv
// Shared definitions for the two-core memory arbiter: default widths,
// lock-owner codes and the "last served" state encoding.
package par_mem_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_C1   = 2'd1,
        LOCK_C2   = 2'd2,
        LOCK_BAD  = 2'd3
    } lock_own_e;

    typedef enum logic [1:0] {
        S_NONE = 2'd0,
        S_C1   = 2'd1,
        S_C2   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/shared_ram_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker; the lock owner overrides fairness
// whenever its own request is eligible. Bit 0 is core1, bit 1 is core2.
module rr_arb2
    import par_mem_pkg::*;
(
    input  logic [1:0] elig,
    input  arb_state_e last,
    input  lock_own_e  prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (prio == LOCK_C1 && elig[0]) begin
            grant = 2'b01;
        end else if (prio == LOCK_C2 && elig[1]) begin
            grant = 2'b10;
        end else begin
            case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // After an idle cycle or a core2 grant, core1 takes the tie
                2'b11:   grant = (last == S_C1) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter: merges two core request streams onto one single-port RAM.
// Stall-cycle counters are built only when SHARED_RAM_ARB_STATS_EN is defined.
module shared_ram_arbiter
    import par_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic              req2,
    input  logic              wren1,
    input  logic              wren2,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wrdata1,
    input  logic [DATA_W-1:0] wrdata2,
    input  logic [1:0]        lock_own,
    output logic              stall1,
    output logic              stall2,
    output logic              rvalid1,
    output logic              rvalid2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
`ifdef SHARED_RAM_ARB_STATS_EN
    output logic [15:0]       stat_stall1,
    output logic [15:0]       stat_stall2,
`endif
    input  logic [DATA_W-1:0] ram_q
);

    lock_own_e         lock;
    logic [1:0]        elig;
    logic [1:0]        grant;
    arb_state_e        last_q, last_d;
    logic [1:0]        rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;

    assign lock = lock_own_e'(lock_own);

    // A write is blocked while the other core (or an invalid code) owns the lock
    always_comb begin
        elig[0] = rst & req1 & ~(wren1 & (lock == LOCK_C2 || lock == LOCK_BAD));
        elig[1] = rst & req2 & ~(wren2 & (lock == LOCK_C1 || lock == LOCK_BAD));
    end

    rr_arb2 u_pick (
        .elig  (elig),
        .last  (last_q),
        .prio  (lock),
        .grant (grant)
    );

    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wren   = 1'b0;
        last_d     = S_NONE;
        if (grant[0]) begin
            ram_addr_d = addr1;
            ram_data_d = wrdata1;
            ram_wren   = wren1;
            last_d     = S_C1;
        end else if (grant[1]) begin
            ram_addr_d = addr2;
            ram_data_d = wrdata2;
            ram_wren   = wren2;
            last_d     = S_C2;
        end
        rd_owner_d = grant & ~{wren2, wren1};
    end

    assign ram_addr = ram_addr_d;
    assign ram_data = ram_data_d;
    assign stall1   = rst & req1 & ~grant[0];
    assign stall2   = rst & req2 & ~grant[1];
    assign rvalid1  = rd_owner_q[0];
    assign rvalid2  = rd_owner_q[1];
    assign rdata1   = rd_owner_q[0] ? ram_q : '0;
    assign rdata2   = rd_owner_q[1] ? ram_q : '0;

`ifdef SHARED_RAM_ARB_STATS_EN
    logic [15:0] stat1_q, stat1_d;
    logic [15:0] stat2_q, stat2_d;

    always_comb begin
        stat1_d = stat1_q;
        stat2_d = stat2_q;
        if (stall1 && stat1_q != 16'hFFFF) stat1_d = stat1_q + 16'd1;
        if (stall2 && stat2_q != 16'hFFFF) stat2_d = stat2_q + 16'd1;
    end

    assign stat_stall1 = stat1_q;
    assign stat_stall2 = stat2_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= S_C2;
            rd_owner_q <= 2'b00;
            ram_addr_q <= '0;
            ram_data_q <= '0;
`ifdef SHARED_RAM_ARB_STATS_EN
            stat1_q    <= 16'd0;
            stat2_q    <= 16'd0;
`endif
        end else begin
            last_q     <= last_d;
            rd_owner_q <= rd_owner_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
`ifdef SHARED_RAM_ARB_STATS_EN
            stat1_q    <= stat1_d;
            stat2_q    <= stat2_d;
`endif
        end
    end

endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Two-core memory-port arbiter that merges the request streams of both processor cores onto one single-port synchronous RAM. It consumes the lock-owner code produced by the lock arbiter and grants the owning core strict priority. When no lock is held it alternates fairly between cores. Stalls the losing core and returns read data to the core that issued the read one cycle after grant.

## Interface
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- req1, req2  in  1  core access request; held high until not stalled
- wren1, wren2  in  1  request is a write (valid with reqN)
- addr1, addr2  in  ADDR_W  core word address
- wrdata1, wrdata2  in  DATA_W  core write data
- lock_own  in  2  0 none, 1 core1, 2 core2, 3 invalid
- stall1, stall2  out  1  request not granted this cycle
- rvalid1, rvalid2  out  1  rdataN valid this cycle
- rdata1, rdata2  out  DATA_W  read data return
- ram_addr  out  ADDR_W  RAM address
- ram_data  out  DATA_W  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  DATA_W  RAM registered read data, valid the cycle after the address edge
- stat_stall1, stat_stall2  out  16  stall-cycle counters (only with ARB_STATS_EN)

## Operation
- FSM state `last` records the core served last: S_NONE, S_C1, S_C2. Reset state is S_C2, so core1 wins the first tie.
- Eligibility: a reqN is eligible unless it is a write and lock_own names the other core. If lock_own=3, all writes are ineligible. Reads are always eligible.
- Grant, combinational:
  - If lock_own=N and core N's request is eligible, core N wins.
  - Otherwise, if exactly one request is eligible, that core wins.
  - If both are eligible, the core not equal to `last` wins (round-robin).
  - If neither is eligible, there is no grant.
- Winner's addr/wrdata/wren drive ram_addr/ram_data/ram_wren. With no grant: ram_wren=0, and ram_addr/ram_data are held at their previous values.
- stallN = reqN & ~grantN. Ineligible writes are stalled, never dropped.
- `last` updates to S_C1/S_C2 on a grant and to S_NONE on an idle cycle. On S_NONE the tie-break favours core1.
- Read return: register rd_owner = winner & ~wren. Next cycle, rvalidN=1 for that owner and rdataN=ram_q. The other core's rdata is held at 0.

## Timing
- Grant and stall: same cycle as the request (0-cycle decision).
- Write: committed at the clk edge that ends the grant cycle.
- Read latency: exactly 1 cycle from grant to rvalid. Back-to-back reads by one core give one rvalid per cycle.
- lock_own change: takes effect the same cycle, with no stale grant.
- Reset values: stall1=stall2=0, rvalid1=rvalid2=0, rdata1=rdata2=0, ram_wren=0, ram_addr=0, ram_data=0, stats=0.
- Reset asserted mid-read: the pending rvalid is discarded. No rvalid is issued after rst deasserts until a new read is granted.
- Simultaneous same-address write and read: only one can be granted, so no RAM collision is possible.

## Configuration
- SHARED_RAM_ARB_STATS_EN defined:
  - stat_stall1/stat_stall2 ports exist.
  - Each counts cycles with stallN=1, saturating at 16'hFFFF.
  - Both clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package par_mem_pkg holds:
  - ADDR_W, DATA_W defaults
  - lock-owner codes LOCK_NONE/LOCK_C1/LOCK_C2/LOCK_BAD
  - FSM state codes S_NONE/S_C1/S_C2
- One sub-module, rr_arb2: a 2-input round-robin picker with priority override. Inputs: eligibility vector, `last`, priority core. Output: one-hot grant.

## Test plan
- Reset, then req1 read addr 5 (RAM[5]=32'hA5A5) alone → stall1=0, ram_addr=5; next cycle rvalid1=1, rdata1=32'hA5A5.
- lock_own=0, both req reads every cycle for 4 cycles → grants alternate C1,C2,C1,C2; each core stalls every other cycle.
- lock_own=1, core2 write addr 3 data 7, core1 idle → stall2=1, ram_wren=0 until lock_own=0; then write commits and RAM[3]=7.
- lock_own=2, both request reads → core2 wins every cycle and stall1 stays 1 throughout.
- lock_own=3, core1 write plus core2 read → core2 read granted, core1 stalled, ram_wren=0.
- With SHARED_RAM_ARB_STATS_EN: hold core1 stalled 10 cycles → stat_stall1=10; reset mid-read → rvalid1=0 and counters=0.
